// File: rtl/bit_periph_pkg.sv
// Shared constants and types for the bit-peripheral input path.
package bit_periph_pkg;

    localparam int N_CH_DEFAULT     = 16;
    localparam int DEBOUNCE_DEFAULT = 8;
    localparam int CNT_W_DEFAULT    = 4;

    typedef logic [N_CH_DEFAULT-1:0] bit_vec_t;

endpackage

// File: rtl/bit_input_filter_ch.sv
// One input channel: 2-flop synchronizer followed by a saturating debounce counter.
module bit_input_filter_ch #(
    parameter int DEBOUNCE = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sync,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1;
    logic [CNT_W-1:0] cnt;
    logic             done;

    // rise/fall are single-cycle indicators that filt toggles on this edge.
    assign done = (sync != filt) && (cnt == CNT_LAST);
    assign rise = done && sync;
    assign fall = done && !sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync  <= 1'b0;
            filt  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync  <= sync1;
            if (sync == filt) begin
                cnt <= '0;
            end else if (done) begin
                filt <= sync;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_input_filter.sv
// Debounced input conditioning with sticky edge flags for the bit-peripheral input bus.
// Optional short-pulse catch register enabled by BIT_INPUT_FILTER_PULSE_CATCH_EN.
module bit_input_filter
    import bit_periph_pkg::*;
#(
    parameter int N_CH     = N_CH_DEFAULT,
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] INPUTFILTER_RAW,
    input  logic            INPUTFILTER_LOAD,
    input  logic            INPUTFILTER_ACK,
    output logic [N_CH-1:0] INPUTFILTER_OUTPUT,
    output logic [N_CH-1:0] INPUTFILTER_RISE,
    output logic [N_CH-1:0] INPUTFILTER_FALL,
    output logic            INPUTFILTER_CHANGED
);

    logic [N_CH-1:0] sync;
    logic [N_CH-1:0] filt;
    logic [N_CH-1:0] rise_set;
    logic [N_CH-1:0] fall_set;
    logic [N_CH-1:0] rise_q;
    logic [N_CH-1:0] fall_q;
    logic            changed_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        bit_input_filter_ch #(
            .DEBOUNCE (DEBOUNCE),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk  (CLK),
            .rst  (RST),
            .raw  (INPUTFILTER_RAW[i]),
            .sync (sync[i]),
            .filt (filt[i]),
            .rise (rise_set[i]),
            .fall (fall_set[i])
        );
    end

    // LOAD and ACK are bare single-cycle strobes (no ready/handshake): each acts
    // on the edge where it is sampled high; a coincident flag set wins over ACK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= (INPUTFILTER_ACK ? '0 : rise_q) | rise_set;
            fall_q    <= (INPUTFILTER_ACK ? '0 : fall_q) | fall_set;
            changed_q <= |(rise_q | fall_q);
        end
    end

    assign INPUTFILTER_RISE    = rise_q;
    assign INPUTFILTER_FALL    = fall_q;
    assign INPUTFILTER_CHANGED = changed_q;

`ifdef BIT_INPUT_FILTER_PULSE_CATCH_EN
    logic [N_CH-1:0] catch_q;

    // Holds any high seen at the synchronizer until the next scan has read it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            catch_q <= '0;
        end else begin
            catch_q <= (INPUTFILTER_LOAD ? '0 : catch_q) | (sync & ~filt);
        end
    end

    assign INPUTFILTER_OUTPUT = filt | catch_q;
`else
    logic unused_ok;

    assign unused_ok          = INPUTFILTER_LOAD ^ (^sync);
    assign INPUTFILTER_OUTPUT = filt;
`endif

endmodule

// File: tb/tb_bit_input_filter.sv
// Directed bench for bit_input_filter with DEBOUNCE=4 (RAW-to-OUTPUT latency 6 edges).
module tb_bit_input_filter;

    localparam int N_CH = 16;

`ifdef BIT_INPUT_FILTER_PULSE_CATCH_EN
    localparam bit CATCH_EN = 1'b1;
`else
    localparam bit CATCH_EN = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST;
    logic [N_CH-1:0] RAW;
    logic            LOAD;
    logic            ACK;
    logic [N_CH-1:0] OUTPUT;
    logic [N_CH-1:0] RISE;
    logic [N_CH-1:0] FALL;
    logic            CHANGED;

    int vectors = 0;
    int errors  = 0;

    bit_input_filter #(
        .N_CH     (N_CH),
        .DEBOUNCE (4),
        .CNT_W    (4)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .INPUTFILTER_RAW     (RAW),
        .INPUTFILTER_LOAD    (LOAD),
        .INPUTFILTER_ACK     (ACK),
        .INPUTFILTER_OUTPUT  (OUTPUT),
        .INPUTFILTER_RISE    (RISE),
        .INPUTFILTER_FALL    (FALL),
        .INPUTFILTER_CHANGED (CHANGED)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_load();
        LOAD = 1'b1;
        tick(1);
        LOAD = 1'b0;
    endtask

    task automatic pulse_ack();
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST  = 1'b1;
        RAW  = 16'hFFFF;
        LOAD = 1'b0;
        ACK  = 1'b0;

        // Reset held 3 edges with all inputs high
        tick(3);
        check("rst_output", OUTPUT, 16'h0000);
        check("rst_rise", RISE, 16'h0000);
        check("rst_fall", FALL, 16'h0000);
        check("rst_changed", CHANGED, 1'b0);
        RST = 1'b0;

        // Output appears on the 6th non-reset edge
        tick(5);
        check("lat_early_output", OUTPUT, 16'h0000);
        tick(1);
        check("lat_output", OUTPUT, 16'hFFFF);
        check("lat_rise", RISE, 16'hFFFF);
        check("lat_changed_same", CHANGED, 1'b0);
        tick(1);
        check("lat_changed_next", CHANGED, 1'b1);

        pulse_ack();
        check("ack_rise_clear", RISE, 16'h0000);
        check("ack_changed_lag", CHANGED, 1'b1);
        tick(1);
        check("ack_changed_clear", CHANGED, 1'b0);

        // Upper byte falls to set up the fall-and-clear case
        RAW = 16'h00FF;
        tick(6);
        check("upper_fall_output", OUTPUT, 16'h00FF);
        check("upper_fall_flags", FALL, 16'hFF00);
        pulse_ack();
        tick(1);
        check("upper_fall_clear", FALL, 16'h0000);
        check("upper_changed_clear", CHANGED, 1'b0);

        // Fall and clear
        RAW = 16'h0000;
        tick(5);
        check("fall_early_output", OUTPUT, 16'h00FF);
        tick(1);
        check("fall_output", OUTPUT, 16'h0000);
        check("fall_flags", FALL, 16'h00FF);
        check("fall_no_rise", RISE, 16'h0000);
        pulse_ack();
        check("fall_ack_clear", FALL, 16'h0000);
        tick(1);
        check("fall_changed_clear", CHANGED, 1'b0);

        // Glitch of 3 cycles on bit 3 is rejected
        RAW = 16'h0008;
        tick(3);
        RAW = 16'h0000;
        tick(8);
        check("glitch3_output", OUTPUT, CATCH_EN ? 16'h0008 : 16'h0000);
        check("glitch3_rise", RISE, 16'h0000);
        pulse_load();
        tick(1);
        check("glitch3_after_load", OUTPUT, 16'h0000);

        // Glitch of 4 cycles on bit 3 gets through at the 6th edge
        RAW = 16'h0008;
        tick(4);
        RAW = 16'h0000;
        tick(1);
        check("glitch4_early_output", OUTPUT, CATCH_EN ? 16'h0008 : 16'h0000);
        tick(1);
        check("glitch4_output", OUTPUT, 16'h0008);
        check("glitch4_rise", RISE, 16'h0008);
        tick(10);
        pulse_load();
        pulse_ack();
        tick(1);
        check("glitch4_settled", OUTPUT, 16'h0000);
        check("glitch4_flags_clear", RISE | FALL, 16'h0000);

        // Bounce on bit 0, then stable high
        RAW = 16'h0001;
        tick(1);
        RAW = 16'h0000;
        tick(1);
        RAW = 16'h0001;
        tick(1);
        RAW = 16'h0000;
        tick(1);
        RAW = 16'h0001;
        tick(5);
        check("bounce_early_output", OUTPUT, CATCH_EN ? 16'h0001 : 16'h0000);
        check("bounce_early_rise", RISE, 16'h0000);
        tick(1);
        check("bounce_output", OUTPUT, 16'h0001);
        check("bounce_rise", RISE, 16'h0001);
        pulse_load();

        // ACK coincides with RISE[5] while RISE[2] is already set
        pulse_ack();
        RAW = 16'h0005;
        tick(6);
        check("coll_rise_pre", RISE, 16'h0004);
        RAW = 16'h0025;
        tick(5);
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
        check("coll_rise", RISE, 16'h0020);
        check("coll_output", OUTPUT, 16'h0025);
        pulse_load();

        // One-cycle pulse on bit 7, read by a later LOAD
        RAW = 16'h00A5;
        tick(1);
        RAW = 16'h0025;
        tick(1);
        check("catch_c2_output", OUTPUT, 16'h0025);
        tick(1);
        check("catch_c3_output", OUTPUT, CATCH_EN ? 16'h00A5 : 16'h0025);
        tick(2);
        LOAD = 1'b1;
        check("catch_load_output", OUTPUT, CATCH_EN ? 16'h00A5 : 16'h0025);
        tick(1);
        LOAD = 1'b0;
        check("catch_after_load", OUTPUT, 16'h0025);
        check("catch_no_rise", RISE, 16'h0020);
        tick(6);
        check("catch_late_output", OUTPUT, 16'h0025);
        check("catch_late_rise", RISE, 16'h0020);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bit_input_filter.md
Name: bit_input_filter

Overview:
- Conditioning stage directly upstream of the bit-peripheral input registers. Its 16-bit filtered vector drives their parallel input bus, and it is sampled when the scan-cycle read strobe fires.
- Each raw field input goes through a 2-flop synchronizer, then a per-channel debounce counter.
- Sticky rising/falling edge flags and an aggregate change flag let the PLC cores detect transitions between scans.

Parameters:
- N_CH, 16, number of input channels; must equal the bit-peripheral input bus width.
- DEBOUNCE, 8, consecutive stable cycles required before a channel's filtered value changes; legal range 1..2^CNT_W.
- CNT_W, 4, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- INPUTFILTER_RAW  in  N_CH  asynchronous field inputs.
- INPUTFILTER_LOAD  in  1  scan read strobe, driven by the same signal as the bit-peripheral read strobe.
- INPUTFILTER_ACK  in  1  single-cycle pulse that clears the edge flags.
- INPUTFILTER_OUTPUT  out  N_CH  filtered vector, registered; feeds the bit-peripheral input bus.
- INPUTFILTER_RISE  out  N_CH  sticky rising-edge flags.
- INPUTFILTER_FALL  out  N_CH  sticky falling-edge flags.
- INPUTFILTER_CHANGED  out  1  registered OR of all RISE and FALL bits.

Behaviour:
- Reset: all synchronizer flops, counters, filtered bits, RISE, FALL, CHANGED and any catch register go to 0 on the first CLK edge with RST=1. Reset mid-debounce discards the partial count.
- Synchronizer: sync[i] is RAW[i] delayed by 2 flops.
- Debounce, per channel, each cycle:
  - sync==filt: cnt <= 0.
  - sync!=filt and cnt < DEBOUNCE-1: cnt <= cnt+1.
  - sync!=filt and cnt == DEBOUNCE-1: filt <= sync, cnt <= 0.
  - A glitch shorter than DEBOUNCE cycles at sync resets the count and never reaches filt.
- Latency: a clean RAW step appears on OUTPUT exactly 2+DEBOUNCE cycles later. With DEBOUNCE=1 this is 3 cycles.
- The counter saturates at DEBOUNCE-1 by construction, so it never wraps.
- Edge flags:
  - When filt changes 0->1, RISE[i] is set in the same cycle OUTPUT changes. When filt changes 1->0, FALL[i] is set in that cycle.
  - ACK clears all RISE and FALL on the next edge.
  - If a set and an ACK coincide, the set wins for that bit; other bits clear.
- CHANGED is registered one cycle after the RISE/FALL update: CHANGED(t+1) = |(RISE|FALL)(t).
- LOAD has no effect on OUTPUT unless the optional feature is enabled. OUTPUT is stable across the LOAD edge because it only changes on debounce completion, which is an ordinary registered update.
- Channels are fully independent; there is no cross-channel state.

Optional Feature:
- Macro: BIT_INPUT_FILTER_PULSE_CATCH_EN.
- Defined: adds a catch[N_CH] register.
  - catch[i] is set whenever sync[i]==1 and filt[i]==0, including glitches shorter than DEBOUNCE.
  - catch is cleared on the cycle after LOAD. A coincident set wins.
  - OUTPUT = filt | catch, so a short high pulse is seen by at least one scan.
  - RISE/FALL still track filt only.
- Undefined: no catch register; OUTPUT = filt.

Decomposition:
- Shared package bit_periph_pkg:
  - N_CH_DEFAULT = 16;
  - typedef bit vector type of width N_CH_DEFAULT;
  - debounce default constants.
- Sub-module bit_input_filter_ch:
  - one channel (sync, counter, filt, edge pulse outputs);
  - instantiated N_CH times with a generate loop;
  - the top level holds the sticky flags, CHANGED and catch logic.

Test Plan (DEBOUNCE=4):
- Reset: hold RST 3 cycles with RAW=16'hFFFF -> OUTPUT, RISE, FALL = 0 and CHANGED=0 during reset. After release, OUTPUT=16'hFFFF exactly 6 cycles after the first non-reset edge; RISE=16'hFFFF; CHANGED=1 one cycle later.
- Glitch reject: RAW[3] high for 3 cycles -> OUTPUT[3] stays 0 and RISE[3]=0. Held for 4 cycles -> OUTPUT[3]=1 at cycle 6.
- Bounce: RAW[0] toggles 1,0,1,0 each cycle, then stays 1 -> OUTPUT[0] rises 6 cycles after the final stable edge, single RISE[0].
- ACK collision: ACK pulse in the same cycle RISE[5] sets while RISE[2] is already set -> RISE=16'h0020 afterwards.
- Fall and clear: OUTPUT=16'h00FF, RAW drops to 0 -> FALL=16'h00FF after 6 cycles; ACK -> FALL=0; CHANGED=0 the following cycle.
- PULSE_CATCH_EN: a 1-cycle RAW[7] pulse -> OUTPUT[7]=1 from cycle 3 until the cycle after the next LOAD, then 0; RISE[7] stays 0. With the macro undefined, OUTPUT[7] stays 0.
